// File: rtl/simon_pkg.sv
// simon_pkg: shared constants, state encoding and word-level helpers for the
// Simon 32/64 datapath (16-bit words, 32 rounds, z0 constant sequence).
package simon_pkg;

  localparam int SIMON_WORD   = 16;
  localparam int SIMON_ROUNDS = 32;

  // z0 sequence written with z0[0] as the leftmost character, so bit i of
  // the sequence lives at vector position 61 - i.
  localparam logic [61:0] SIMON_Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  // ~k ^ 3 folded into a single constant: k ^ 16'hFFFC.
  localparam logic [15:0] SIMON_C = 16'hFFFC;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPAND  = 2'd1,
    DECRYPT = 2'd2,
    DONE    = 2'd3
  } simon_state_e;

  function automatic logic [15:0] simon_rol(input logic [15:0] v, input int n);
    return (v << n) | (v >> (SIMON_WORD - n));
  endfunction

  function automatic logic [15:0] simon_ror(input logic [15:0] v, input int n);
    return (v >> n) | (v << (SIMON_WORD - n));
  endfunction

  // Simon round function f(v) = (rol1 & rol8) ^ rol2.
  function automatic logic [15:0] simon_f(input logic [15:0] v);
    return (simon_rol(v, 1) & simon_rol(v, 8)) ^ simon_rol(v, 2);
  endfunction

  // Next round key k[i+4] from k[i], k[i+1], k[i+3] and the step index i.
  function automatic logic [15:0] simon_key_next(
    input logic [15:0] k_i,
    input logic [15:0] k_i1,
    input logic [15:0] k_i3,
    input logic [4:0]  idx
  );
    logic [15:0] tmp;
    logic        z_bit;
    tmp   = simon_ror(k_i3, 3) ^ k_i1;
    tmp   = tmp ^ simon_ror(tmp, 1);
    z_bit = SIMON_Z0[6'd61 - {1'b0, idx}];
    return SIMON_C ^ k_i ^ tmp ^ {15'd0, z_bit};
  endfunction

endpackage

// File: rtl/simon_inv_round.sv
// simon_inv_round: one combinational inverse Simon round.
//   x, y     : current state words
//   k        : round key for this round
//   x_next   : becomes y
//   y_next   : x ^ f(y) ^ k
module simon_inv_round
  import simon_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] k,
  output logic [15:0] x_next,
  output logic [15:0] y_next
);

  assign x_next = y;
  assign y_next = x ^ simon_f(y) ^ k;

endmodule

// File: rtl/simon_decrypt.sv
// simon_decrypt: iterative Simon 32/64 decryption engine.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake (in_ready high only in IDLE)
//   in_block           : ciphertext, x = [31:16], y = [15:0]
//   in_key             : key words k0..k3 at [15:0]..[63:48]
//   in_key_reuse       : skip expansion and reuse the buffered round keys
//   out_valid/out_ready: output handshake, out_valid held until accepted
//   out_block          : plaintext, same packing as in_block
// A full key costs 28 expansion cycles plus 32 round cycles; a reused key
// costs only the 32 round cycles.
module simon_decrypt
  import simon_pkg::*;
#(
  parameter bit KEY_REUSE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_block,
  input  logic [63:0] in_key,
  input  logic        in_key_reuse,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_block
);

  simon_state_e state_reg, state_next;
  logic [4:0]   cnt_reg, cnt_next;           // expansion step or round index
  logic [15:0]  x_reg, x_next;
  logic [15:0]  y_reg, y_next;
  logic         keys_loaded_reg, keys_loaded_next;
  logic         out_valid_reg, out_valid_next;
  logic [31:0]  out_block_reg, out_block_next;

  logic [SIMON_WORD-1:0] rk_reg [SIMON_ROUNDS];

  logic        reuse_ok;
  logic        load_key;
  logic [15:0] k_new;
  logic [15:0] round_k;
  logic [15:0] rx, ry;

  // Reuse is only honoured once a complete schedule sits in the buffer.
  assign reuse_ok = KEY_REUSE_EN && in_key_reuse && keys_loaded_reg;
  assign load_key = (state_reg == IDLE) && in_valid && !reuse_ok;

  assign k_new   = simon_key_next(rk_reg[cnt_reg],
                                  rk_reg[cnt_reg + 5'd1],
                                  rk_reg[cnt_reg + 5'd3],
                                  cnt_reg);
  assign round_k = rk_reg[cnt_reg];

  simon_inv_round u_inv_round (
    .x      (x_reg),
    .y      (y_reg),
    .k      (round_k),
    .x_next (rx),
    .y_next (ry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= 5'd0;
      x_reg           <= 16'd0;
      y_reg           <= 16'd0;
      keys_loaded_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_block_reg   <= 32'd0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      keys_loaded_reg <= keys_loaded_next;
      out_valid_reg   <= out_valid_next;
      out_block_reg   <= out_block_next;
    end
  end

  // Round-key buffer: the four key words land in slots 0..3 on a fresh
  // load, then EXPAND fills slot i+4 on step i. EXPAND and DECRYPT never
  // overlap, so the combinational reads never see a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_key) begin
        for (int i = 0; i < 4; i++) begin
          rk_reg[i] <= in_key[16*i +: 16];
        end
      end else if (state_reg == EXPAND) begin
        rk_reg[cnt_reg + 5'd4] <= k_new;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    x_next           = x_reg;
    y_next           = y_reg;
    keys_loaded_next = keys_loaded_reg;
    out_valid_next   = out_valid_reg;
    out_block_next   = out_block_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          x_next = in_block[31:16];
          y_next = in_block[15:0];
          if (reuse_ok) begin
            state_next = DECRYPT;
            cnt_next   = 5'd31;
          end else begin
            state_next = EXPAND;
            cnt_next   = 5'd0;
          end
        end
      end
      EXPAND: begin
        if (cnt_reg == 5'd27) begin
          state_next       = DECRYPT;
          cnt_next         = 5'd31;
          keys_loaded_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      DECRYPT: begin
        x_next = rx;
        y_next = ry;
        if (cnt_reg == 5'd0) begin
          state_next     = DONE;
          out_valid_next = 1'b1;
          out_block_next = {rx, ry};
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign out_block = out_block_reg;

endmodule
